mips_ifetch_buf: RTL and testbench
==================================

// Module: mips_ifetch_buf
// PURPOSE
//  Instruction prefetch buffer between the instruction memory (IM) and the mips core's fetch stage.
//  Issues sequential word fetches to IM and queues {pc, instruction} pairs in a small FIFO.
//  Hands the pairs to the core over a valid/ready handshake.
//  On a redirect (branch/jump), it flushes the queue and discards the in-flight IM response.
// PARAMETERS
//  DEPTH     4             FIFO entries; must be a power of 2 and >= 2
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  CLK       in   1   single clock; all state updates on the rising edge
//  Z_R       in   1   reset; synchronous, active-high
//  IM_REQ    out  1   fetch request to IM, issued this cycle
//  IM_ADDR   out  32  byte address of the fetch; bits [1:0] always 0
//  IM_DATA   in   32  instruction word; valid the cycle after IM_REQ
//  IF_VALID  out  1   FIFO head holds a valid entry
//  IF_READY  in   1   core accepts the head this cycle
//  IF_INST   out  32  head instruction
//  IF_PC     out  32  head pc
//  REDIR_EN  in   1   redirect fetch stream
//  REDIR_PC  in   32  redirect target; bits [1:0] are ignored and forced to 0
// BEHAVIOUR
//  Reset (Z_R=1 at an edge):
//   - fetch_pc <= RESET_PC; FIFO count and both pointers <= 0; inflight <= 0; kill <= 0.
//   - During and after reset: IM_REQ=0, IF_VALID=0, IF_INST=0, IF_PC=0.
//   - Reset overrides every other input in the same cycle.
//  Issue:
//   - IM_REQ=1 in cycle n iff !Z_R && !REDIR_EN && (count + inflight + 1 <= DEPTH).
//   - Entries popped in cycle n do not add credit until cycle n+1.
//   - IM_ADDR = fetch_pc; on issue, fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 0.
//  Response:
//   - inflight <= IM_REQ. In cycle n+1, IM_DATA is captured with pc = IM_ADDR of cycle n.
//   - The pair is pushed unless kill=1 (then dropped). The entry is visible at IF_* in cycle n+2.
//  Pop:
//   - IF_VALID = (count != 0); IF_INST/IF_PC come from the registered head entry; there is no bypass.
//   - On IF_VALID && IF_READY, the read pointer advances (mod DEPTH).
//   - Push and pop in the same cycle: count unchanged.
//   - The credit rule guarantees no push when full; a push when full is an assertion failure.
//  Redirect (REDIR_EN=1 in cycle n):
//   - FIFO is cleared at the edge; a pop in cycle n is ignored; no issue in cycle n.
//   - kill <= inflight, so a response arriving in cycle n+1 is dropped.
//   - fetch_pc <= {REDIR_PC[31:2], 2'b00}; issue resumes in cycle n+1.
//   - The first redirected entry appears at IF_* in cycle n+3.
//   - Back-to-back redirects: the last one wins.
//  Timing:
//   - Startup latency from reset release to first IF_VALID: 2 cycles.
//   - Steady-state throughput: 1 instruction per cycle with IF_READY held at 1.
// STRUCTURE
//  mips_pkg:
//   - localparam WORD_W=32, PC_INC=4.
//   - typedef struct packed {logic [31:0] pc; logic [31:0] inst;} fetch_entry_t.
//  Sub-module mips_sync_fifo (DEPTH x fetch_entry_t):
//   - Ports: push, pop, clear, count, head.
//   - Synchronous clear; same reset rules as this block.
//  Top level holds fetch_pc, the inflight/kill flags and the credit logic.
// TESTING
//  1. Release Z_R with IF_READY=1 and IM[k]=32'h2000_0000+k.
//     -> IF_VALID rises 2 cycles later; IF_PC=0,4,8,... and IF_INST=2000_0000,2000_0001,... on consecutive cycles.
//  2. Hold IF_READY=0 for 10 cycles.
//     -> exactly 4 IM_REQs, then IM_REQ=0 with count=4.
//     -> Raise IF_READY: IF_PC 0x0,0x4,0x8,0xC, then 0x10, with no gap or loss.
//  3. REDIR_EN with REDIR_PC=32'h0000_0400 while a fetch is in flight.
//     -> that response is never presented; 3 cycles later IF_PC=0x400, then 0x404.
//  4. REDIR_PC=32'h0000_0403.
//     -> IM_ADDR=0x400 next cycle; IF_PC=0x400.
//  5. RESET_PC=32'hFFFF_FFF8.
//     -> IF_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6. Assert Z_R with the FIFO full and a fetch in flight.
//     -> next cycle IF_VALID=0 and IM_REQ=0; after release, first IM_ADDR=RESET_PC and the stale response is not pushed.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the mips instruction fetch path.
package mips_pkg;
  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/mips_sync_fifo.sv
// Synchronous FIFO of fetch entries with a registered head and a synchronous clear.
module mips_sync_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wdata,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];
  logic          w_pop;

  assign w_pop = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push) r_mem[r_wptr] <= wdata;
  end

  // Upstream credit accounting must never let a push reach a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clear)
    !(push && (r_count == FULL)));

  assign count = r_count;
  assign head  = r_mem[r_rptr];
endmodule

// File: rtl/mips_ifetch_buf.sv
// Instruction prefetch buffer: sequential IM fetches queued as {pc, inst} for the core.
module mips_ifetch_buf
  import mips_pkg::*;
#(
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              Z_R,
  output logic              IM_REQ,
  output logic [WORD_W-1:0] IM_ADDR,
  input  logic [WORD_W-1:0] IM_DATA,
  output logic              IF_VALID,
  input  logic              IF_READY,
  output logic [WORD_W-1:0] IF_INST,
  output logic [WORD_W-1:0] IF_PC,
  input  logic              REDIR_EN,
  input  logic [WORD_W-1:0] REDIR_PC
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [WORD_W-1:0] PC_MASK = ~32'h3;

  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] r_req_pc;
  logic              r_inflight;
  logic              r_kill;

  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_used;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  fetch_entry_t      w_head;
  fetch_entry_t      w_wdata;

  // Credit counts queued entries plus the outstanding fetch; pops free space a cycle later.
  assign w_used  = w_count + CW'(r_inflight);
  assign w_issue = !Z_R && !REDIR_EN && (w_used < CW'(DEPTH));
  assign w_push  = r_inflight && !r_kill && !REDIR_EN;
  assign w_valid = !Z_R && (w_count != '0);
  assign w_pop   = w_valid && IF_READY && !REDIR_EN;
  assign w_wdata = '{pc: r_req_pc, inst: IM_DATA};

  always_ff @(posedge CLK) begin
    if (Z_R) begin
      r_fetch_pc <= RESET_PC & PC_MASK;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= REDIR_EN && r_inflight;
      if (w_issue) r_req_pc <= r_fetch_pc;
      if (REDIR_EN)     r_fetch_pc <= REDIR_PC & PC_MASK;
      else if (w_issue) r_fetch_pc <= r_fetch_pc + PC_INC;
    end
  end

  mips_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (Z_R),
    .push  (w_push),
    .pop   (w_pop),
    .clear (REDIR_EN),
    .wdata (w_wdata),
    .count (w_count),
    .head  (w_head)
  );

  assign IM_REQ   = w_issue;
  assign IM_ADDR  = r_fetch_pc;
  assign IF_VALID = w_valid;
  assign IF_PC    = w_valid ? w_head.pc   : '0;
  assign IF_INST  = w_valid ? w_head.inst : '0;
endmodule

// File: tb/tb_mips_ifetch_buf.sv
// Bench for mips_ifetch_buf: queue-based reference model plus pinned literal expectations.
module tb_mips_ifetch_buf;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] M_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        Z_R, IF_READY, REDIR_EN;
  logic [31:0] REDIR_PC, IM_DATA, b_im_data;
  logic        IM_REQ, IF_VALID, b_im_req, b_if_valid;
  logic [31:0] IM_ADDR, IF_INST, IF_PC, b_im_addr, b_if_inst, b_if_pc;

  always #5 clk = ~clk;

  mips_ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(M_RESET_PC)) dut (
    .CLK(clk), .Z_R(Z_R), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_DATA(IM_DATA),
    .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_INST(IF_INST), .IF_PC(IF_PC),
    .REDIR_EN(REDIR_EN), .REDIR_PC(REDIR_PC));

  mips_ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(clk), .Z_R(Z_R), .IM_REQ(b_im_req), .IM_ADDR(b_im_addr), .IM_DATA(b_im_data),
    .IF_VALID(b_if_valid), .IF_READY(IF_READY), .IF_INST(b_if_inst), .IF_PC(b_if_pc),
    .REDIR_EN(REDIR_EN), .REDIR_PC(REDIR_PC));

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return 32'h2000_0000 + (a >> 2);
  endfunction

  // Reference model: the queue the core should see, the outstanding fetch and the next address.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [31:0] m_next = M_RESET_PC;
  int          cyc_no = 0;

  always @(posedge clk) begin
    bit req;
    cyc_no++;
    if (Z_R) begin
      mq.delete();
      m_next = M_RESET_PC;
      m_pend = 1'b0;
    end else begin
      req = !REDIR_EN && (mq.size() + int'(m_pend) < int'(DEPTH));
      if (REDIR_EN) mq.delete();
      else begin
        if (mq.size() != 0 && IF_READY) void'(mq.pop_front());
        if (m_pend) mq.push_back('{m_pend_pc, im_word(m_pend_pc)});
      end
      m_pend    = req;
      m_pend_pc = m_next;
      if (REDIR_EN) m_next = REDIR_PC & ~32'h3;
      else if (req) m_next = m_next + 32'd4;
    end
  end

  typedef struct { int cyc; int sel; logic [31:0] exp; } lit_t;
  lit_t lits[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "lit_if_valid";  1: return "lit_if_pc";    2: return "lit_if_inst";
      3: return "lit_im_req";    4: return "lit_im_addr";  5: return "lit2_if_pc";
      6: return "lit2_if_valid"; 7: return "lit2_im_addr"; default: return "lit_unknown";
    endcase
  endfunction

  function automatic logic [31:0] act_of(input int sel);
    case (sel)
      0: return 32'(IF_VALID);   1: return IF_PC;     2: return IF_INST;
      3: return 32'(IM_REQ);     4: return IM_ADDR;   5: return b_if_pc;
      6: return 32'(b_if_valid); 7: return b_im_addr; default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_no, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit ev, er;
    ev = !Z_R && (mq.size() != 0);
    chk("if_valid", 32'(IF_VALID), 32'(ev));
    if (ev) begin
      chk("if_pc", IF_PC, mq[0].pc);
      chk("if_inst", IF_INST, mq[0].inst);
    end else if (Z_R) begin
      chk("if_pc_rst", IF_PC, 32'h0);
      chk("if_inst_rst", IF_INST, 32'h0);
    end
    er = !Z_R && !REDIR_EN && (mq.size() + int'(m_pend) < int'(DEPTH));
    chk("im_req", 32'(IM_REQ), 32'(er));
    if (er) chk("im_addr", IM_ADDR, m_next);
    foreach (lits[i]) if (lits[i].cyc == cyc_no) chk(sel_name(lits[i].sel), act_of(lits[i].sel), lits[i].exp);
  end

  logic        cap_req, cap2_req;
  logic [31:0] cap_addr, cap2_addr;

  task automatic lit(input int sel, input logic [31:0] e);
    lits.push_back('{cyc_no, sel, e});
  endtask

  task automatic step(input logic z, input logic rdy, input logic rd, input logic [31:0] rpc);
    Z_R = z; IF_READY = rdy; REDIR_EN = rd; REDIR_PC = rpc;
    #1;
  endtask

  // Instruction memory answers the cycle after a request.
  task automatic adv();
    #7;
    cap_req = IM_REQ;   cap_addr = IM_ADDR;
    cap2_req = b_im_req; cap2_addr = b_im_addr;
    @(posedge clk);
    #1;
    IM_DATA   = cap_req  ? im_word(cap_addr)  : 32'hDEAD_BEEF;
    b_im_data = cap2_req ? im_word(cap2_addr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    Z_R = 1'b1; IF_READY = 1'b1; REDIR_EN = 1'b0; REDIR_PC = '0;
    IM_DATA = '0; b_im_data = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      if (i == 2) begin lit(3, 0); lit(0, 0); end
      adv();
    end

    // Startup, streaming, and the wrap-around instance.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      case (i)
        0: begin lit(3, 1); lit(4, 32'h0); lit(7, 32'hFFFF_FFF8); end
        1: lit(0, 0);
        2: begin lit(0, 1); lit(1, 32'h0); lit(2, 32'h2000_0000); lit(5, 32'hFFFF_FFF8); end
        3: begin lit(1, 32'h4); lit(2, 32'h2000_0001); lit(5, 32'hFFFF_FFFC); end
        4: begin lit(1, 32'h8); lit(5, 32'h0); lit(6, 1); end
        default: ;
      endcase
      adv();
    end

    // Stall fills the queue, then drain without gaps.
    for (int i = 0; i < 2; i++) begin step(1, 0, 0, 0); adv(); end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      lit(3, (i < 4) ? 32'h1 : 32'h0);
      if (i == 9) begin lit(0, 1); lit(1, 32'h0); end
      adv();
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      if (i < 5) lit(1, 32'(4 * i));
      if (i == 1) begin lit(3, 1); lit(4, 32'h10); end
      if (i == 5) lit(3, 1);
      adv();
    end

    // Redirect with a fetch outstanding.
    step(0, 1, 1, 32'h0000_0400);
    lit(3, 0); lit(0, 1); lit(1, 32'h18);
    adv();
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0);
      case (i)
        1: begin lit(3, 1); lit(4, 32'h400); lit(0, 0); end
        2: lit(0, 0);
        3: begin lit(1, 32'h400); lit(2, 32'h2000_0100); end
        4: begin lit(1, 32'h404); lit(2, 32'h2000_0101); end
        5: lit(1, 32'h408);
        default: ;
      endcase
      adv();
    end

    // Back-to-back redirects, last one unaligned.
    step(0, 1, 1, 32'h0000_0200); lit(3, 0); adv();
    step(0, 1, 1, 32'h0000_0403); lit(3, 0); adv();
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      case (i)
        0: begin lit(4, 32'h400); lit(3, 1); lit(0, 0); end
        1: lit(0, 0);
        2: begin lit(1, 32'h400); lit(2, 32'h2000_0100); end
        3: lit(1, 32'h404);
        default: ;
      endcase
      adv();
    end

    // Reset with credits exhausted and a fetch outstanding.
    step(0, 0, 0, 0); lit(3, 1); adv();
    step(0, 0, 0, 0); lit(3, 1); adv();
    step(1, 0, 0, 0); lit(3, 0); lit(0, 0); adv();
    step(1, 0, 0, 0); lit(3, 0); lit(0, 0); adv();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      case (i)
        0: begin lit(3, 1); lit(4, 32'h0); end
        1: lit(0, 0);
        2: begin lit(0, 1); lit(1, 32'h0); lit(2, 32'h2000_0000); end
        3: lit(1, 32'h4);
        default: ;
      endcase
      adv();
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
